// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier datapath.
// Moore outputs are decoded from the next state and registered, so they track the current state without glitches.
module booth_controller #(
    parameter int N_BITS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       qn1,
    input  logic       qm1,
    input  logic       eqz,
    output logic       busy,
    output logic       done,
    output logic       loadA,
    output logic       clearA,
    output logic       shiftA,
    output logic       loadQ,
    output logic       shiftQ,
    output logic       clearQ,
    output logic       clearF,
    output logic       enableD,
    output logic       loadM,
    output logic       addsub,
    output logic       decc,
    output logic       loadcntr,
    output logic       clearcntr,
    output logic [3:0] cycle
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_EVAL  = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic load_a;
        logic clear_a;
        logic shift_a;
        logic load_q;
        logic shift_q;
        logic clear_q;
        logic clear_f;
        logic enable_d;
        logic load_m;
        logic addsub;
        logic decc;
        logic loadcntr;
        logic clearcntr;
    } ctrl_t;

    localparam logic [3:0] CYCLE_C   = 4'(N_BITS);
    localparam ctrl_t      CTRL_IDLE = 15'b000_0000_0000_0001;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // State and registered-output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state logic; abort wins over everything except the fixed DONE->IDLE step.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = start ? S_INIT : S_IDLE;
                S_INIT:  state_d = S_EVAL;
                S_EVAL: begin
                    if (eqz) begin
                        state_d = S_DONE;
                    end else begin
                        case ({qn1, qm1})
                            2'b10:   state_d = S_SUB;
                            2'b01:   state_d = S_ADD;
                            default: state_d = S_SHIFT;
                        endcase
                    end
                end
                S_ADD:   state_d = S_SHIFT;
                S_SUB:   state_d = S_SHIFT;
                S_SHIFT: state_d = S_EVAL;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode of the state being entered.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_IDLE: begin
                ctrl_d.clearcntr = 1'b1;
            end
            S_INIT: begin
                ctrl_d.busy     = 1'b1;
                ctrl_d.clear_a  = 1'b1;
                ctrl_d.clear_f  = 1'b1;
                ctrl_d.load_m   = 1'b1;
                ctrl_d.load_q   = 1'b1;
                ctrl_d.loadcntr = 1'b1;
            end
            S_EVAL: begin
                ctrl_d.busy = 1'b1;
            end
            S_ADD: begin
                ctrl_d.busy   = 1'b1;
                ctrl_d.addsub = 1'b1;
                ctrl_d.load_a = 1'b1;
            end
            S_SUB: begin
                ctrl_d.busy   = 1'b1;
                ctrl_d.addsub = 1'b0;
                ctrl_d.load_a = 1'b1;
            end
            S_SHIFT: begin
                ctrl_d.busy     = 1'b1;
                ctrl_d.shift_a  = 1'b1;
                ctrl_d.shift_q  = 1'b1;
                ctrl_d.enable_d = 1'b1;
                ctrl_d.decc     = 1'b1;
            end
            S_DONE: begin
                ctrl_d.busy = 1'b1;
                ctrl_d.done = 1'b1;
            end
            default: begin
                ctrl_d = CTRL_IDLE;
            end
        endcase
    end

    assign busy      = ctrl_q.busy;
    assign done      = ctrl_q.done;
    assign loadA     = ctrl_q.load_a;
    assign clearA    = ctrl_q.clear_a;
    assign shiftA    = ctrl_q.shift_a;
    assign loadQ     = ctrl_q.load_q;
    assign shiftQ    = ctrl_q.shift_q;
    assign clearQ    = ctrl_q.clear_q;
    assign clearF    = ctrl_q.clear_f;
    assign enableD   = ctrl_q.enable_d;
    assign loadM     = ctrl_q.load_m;
    assign addsub    = ctrl_q.addsub;
    assign decc      = ctrl_q.decc;
    assign loadcntr  = ctrl_q.loadcntr;
    assign clearcntr = ctrl_q.clearcntr;
    assign cycle     = CYCLE_C;

endmodule

// File: tb/tb_booth_controller.sv
// Bench: controller driving a behavioural 5-bit Booth datapath, checked against signed products
// and a latency derived from the Booth recoding of the multiplier.
module tb_booth_controller;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic qn1, qm1, eqz;
    logic busy, done, loadA, clearA, shiftA, loadQ, shiftQ, clearQ, clearF;
    logic enableD, loadM, addsub, decc, loadcntr, clearcntr;
    logic [3:0] cycle;

    logic signed [4:0] m_in, q_in;
    logic signed [4:0] a_r, q_r, m_r;
    logic              qm1_r;
    logic [3:0]        cnt_r;

    int n_cmp = 0;
    int n_bad = 0;
    time last_done_t;

    always #5 clk = ~clk;

    booth_controller #(.N_BITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .qn1(qn1), .qm1(qm1), .eqz(eqz),
        .busy(busy), .done(done), .loadA(loadA), .clearA(clearA), .shiftA(shiftA),
        .loadQ(loadQ), .shiftQ(shiftQ), .clearQ(clearQ), .clearF(clearF),
        .enableD(enableD), .loadM(loadM), .addsub(addsub), .decc(decc),
        .loadcntr(loadcntr), .clearcntr(clearcntr), .cycle(cycle)
    );

    // Behavioural Booth datapath driven by the controller.
    always @(posedge clk) begin
        if (clearA)      a_r <= 5'sd0;
        else if (loadA)  a_r <= addsub ? a_r + m_r : a_r - m_r;
        else if (shiftA) a_r <= a_r >>> 1;
        if (loadQ)       q_r <= q_in;
        else if (clearQ) q_r <= 5'sd0;
        else if (shiftQ) q_r <= {a_r[0], q_r[4:1]};
        if (clearF)       qm1_r <= 1'b0;
        else if (enableD) qm1_r <= q_r[0];
        if (loadM) m_r <= m_in;
        if (clearcntr)     cnt_r <= 4'd0;
        else if (loadcntr) cnt_r <= cycle;
        else if (decc)     cnt_r <= cnt_r - 4'd1;
    end

    assign qn1 = q_r[0];
    assign qm1 = qm1_r;
    assign eqz = (cnt_r == 4'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Number of non-zero Booth digits = number of add/subtract steps.
    function automatic int booth_k(input logic [4:0] q);
        int k = 0;
        logic prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (q[i] != prev) k++;
            prev = q[i];
        end
        return k;
    endfunction

    function automatic logic [9:0] ref_prod(input logic signed [4:0] m, input logic signed [4:0] q);
        logic signed [9:0] p;
        p = m * q;
        return p;
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    task automatic run_op(input logic signed [4:0] m, input logic signed [4:0] q, input bit hold);
        int n = 0, n_load = 0, viol = 0;
        bit found = 1'b0;
        int k = booth_k(q);
        m_in = m; q_in = q; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (int'(loadA) + int'(shiftA) + int'(clearA) > 1) viol++;
            if (loadcntr && decc) viol++;
            if (!busy) viol++;
            if (done) begin
                found = 1'b1;
                last_done_t = $time;
                break;
            end
            if (loadA) n_load++;
            n++;
        end
        check("done_seen", 32'(found), 32'd1);
        check("latency", n, 2 + 2 * N + k);
        check("addsub_visits", n_load, k);
        check("invariants", viol, 0);
        check("product", {22'd0, a_r, q_r}, {22'd0, ref_prod(m, q)});
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("idle_gap_busy", 32'(busy), 32'd0);
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    logic [11:0] ctl;
    assign ctl = {loadA, clearA, shiftA, loadQ, shiftQ, clearQ, clearF, enableD, loadM, addsub, decc, loadcntr};

    initial begin
        int nd, nshift, k;
        bit found;
        time t1;
        logic signed [4:0] rm, rq;

        rst = 1'b1; start = 1'b1; abort = 1'b0; m_in = 5'sd0; q_in = 5'sd0;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cycle", 32'(cycle), 32'd5);
        check("rst_clearcntr", 32'(clearcntr), 32'd1);
        check("rst_ctl", 32'(ctl), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_clearcntr", 32'(clearcntr), 32'd1);
        check("post_rst_ctl", 32'(ctl), 32'd0);

        // Directed operand cases with known results.
        run_op(5'sd7, -5'sd3, 1'b0);
        check("m7_q-3_prod", 32'({a_r, q_r}), 32'(10'b1111101011));
        run_op(5'sd9, 5'sd0, 1'b0);
        run_op(5'sd5, -5'sd1, 1'b0);

        // Reset during the third SHIFT of an operation.
        m_in = 5'sd7; q_in = -5'sd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nshift = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (shiftA) begin
                nshift++;
                if (nshift == 3) found = 1'b1;
            end
            if (!found) @(negedge clk);
        end
        check("third_shift_seen", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_clearcntr", 32'(clearcntr), 32'd1);
        count_done(20, nd);
        check("rst_mid_no_done", nd, 0);
        run_op(5'sd3, 5'sd2, 1'b0);
        check("m3_q2_prod", 32'({a_r, q_r}), 32'd6);

        // Abort during ADD.
        m_in = 5'sd3; q_in = 5'sd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (loadA && addsub) found = 1'b1;
            else @(negedge clk);
        end
        check("add_seen", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        count_done(30, nd);
        check("abort_no_done", nd, 0);

        // Abort and start together in IDLE: abort wins.
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_start_idle", 32'(busy), 32'd0);
        abort = 1'b0; start = 1'b0;
        @(negedge clk);

        // Start pulsed while busy is ignored: exactly one done.
        m_in = 5'sd4; q_in = 5'sd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count_done(40, nd);
        check("busy_start_ignored", nd, 1);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Start held high: back-to-back operations.
        run_op(5'sd6, 5'sd10, 1'b1);
        t1 = last_done_t;
        run_op(5'sd6, 5'sd10, 1'b1);
        k = booth_k(5'sd10);
        check("b2b_spacing", 32'((last_done_t - t1) / 10), 32'(2 + 2 * N + k + 2));
        start = 1'b0;
        @(negedge clk);

        // Random operands; M=-16 is outside the range 5-bit Booth can add/subtract.
        for (int r = 0; r < 25; r++) begin
            rm = 5'($urandom_range(0, 30)) - 5'sd15;
            rq = 5'($urandom_range(0, 31));
            run_op(rm, rq, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
